// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared HI/LO multiply/divide unit in EX: drives the pipelined
// multiplier or the handshake divider, stalls the pipe, and writes HI/LO once.
// Optional zero-operand multiply bypass: define MULDIV_ZERO_SKIP_EN.
module muldiv_ctrl #(
  parameter int unsigned MULT_LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  output logic        mult_sclr,
  input  logic [63:0] mult_p,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        stall,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MULT = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      a_q, b_q;
  logic             neg_q;
  logic             sdiv_q;
  logic [31:0]      hi_q, lo_q;

  logic             abort;
  logic             accept;
  logic             signed_mult;
  logic             zero_skip;
  logic [31:0]      a_mag, b_mag;
  logic [63:0]      prod_fix;
  logic             capture;
  logic [63:0]      cap_val;

  // Reset mid-operation aborts exactly like a flush.
  assign abort       = flush | rst;
  assign accept      = (state == S_IDLE) & req_valid & ~abort;
  assign signed_mult = (req_op == 2'b00);

  // Magnitudes for MULT; 0x80000000 negates to itself, which is the right unsigned value.
  assign a_mag = (signed_mult & src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign b_mag = (signed_mult & src_b[31]) ? (~src_b + 32'd1) : src_b;

`ifdef MULDIV_ZERO_SKIP_EN
  assign zero_skip = ~req_op[1] & ((src_a == 32'd0) | (src_b == 32'd0));
`else
  assign zero_skip = 1'b0;
`endif

  assign prod_fix = neg_q ? (~mult_p + 64'd1) : mult_p;

  assign mult_a = a_q;
  assign mult_b = b_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = (state != S_IDLE);

  // Next state, capture control and handshake outputs.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    cap_val    = prod_fix;
    stall      = 1'b0;
    hilo_we    = 1'b0;
    mult_sclr  = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_annul  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          stall = 1'b1;
          if (zero_skip) begin
            state_nxt = S_DONE;
            capture   = 1'b1;
            cap_val   = 64'd0;
          end else if (req_op[1]) begin
            state_nxt = S_DIV;
          end else begin
            state_nxt = S_MULT;
            cnt_nxt   = '0;
          end
        end
      end
      S_MULT: begin
        stall     = ~abort;
        mult_sclr = abort;
        if (cnt == CNT_LAST) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DIV: begin
        stall      = ~abort;
        div_annul  = abort;
        div_start  = ~abort;
        div_signed = ~abort & sdiv_q;
        if (div_ready) begin
          capture   = 1'b1;
          cap_val   = div_result;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        hilo_we   = ~abort;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      capture   = 1'b0;
    end
  end

  // State, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      neg_q  <= 1'b0;
      sdiv_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        a_q    <= a_mag;
        b_q    <= b_mag;
        neg_q  <= signed_mult & (src_a[31] ^ src_b[31]);
        sdiv_q <= ~req_op[0];
      end
      if (capture) begin
        {hi_q, lo_q} <= cap_val;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: pipelined multiplier model, scripted divider handshake,
// and a scoreboard of expected HI/LO values checked when hilo_we fires.
module tb_muldiv_ctrl;

  localparam int unsigned MULT_LAT = 5;
  localparam logic [63:0] JUNK     = 64'hDEAD_BEEF_CAFE_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic [31:0] mult_a, mult_b;
  logic        mult_sclr;
  logic [63:0] mult_p;
  logic        div_start, div_signed, div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stall, busy, hilo_we;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int passed = 0;
  logic [63:0] sb[$];
  logic [63:0] last_exp = 64'd0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .mult_a(mult_a), .mult_b(mult_b), .mult_sclr(mult_sclr), .mult_p(mult_p),
    .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready),
    .stall(stall), .busy(busy), .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out)
  );

  // Multiplier model: product of the registered operands appears MULT_LAT-1 edges later.
  logic [63:0] pipe [0:MULT_LAT-2];
  always @(posedge clk) begin
    if (rst || mult_sclr) begin
      for (int i = 0; i < MULT_LAT - 1; i++) pipe[i] <= 64'd0;
    end else begin
      pipe[0] <= {32'd0, mult_a} * {32'd0, mult_b};
      for (int i = 1; i < MULT_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mult_p = pipe[MULT_LAT-2];

  // Drives one request and follows it to hilo_we (we_at = -1 on timeout); no checking here.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv, input int dlat, input logic [63:0] dres,
                        output int we_at, output int stall_n, output int start_n,
                        output int signed_n, output logic [31:0] ma, output logic [31:0] mb,
                        output logic [63:0] got);
    we_at = -1; stall_n = 0; start_n = 0; signed_n = 0; ma = '0; mb = '0; got = '0;
    req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
    sb.push_back(expv);
    for (int k = 0; k < 64 && we_at < 0; k++) begin
      div_ready  = op[1] && (k == dlat + 1);
      div_result = div_ready ? dres : JUNK;
      @(negedge clk);
      if (stall) stall_n++;
      if (div_start) start_n++;
      if (div_signed) signed_n++;
      if (k == 1) begin ma = mult_a; mb = mult_b; end
      if (hilo_we) begin we_at = k; got = {hi_out, lo_out}; end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    div_ready  = 1'b0;
    div_result = JUNK;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; src_a = '0; src_b = '0;
    flush = 1'b0; div_ready = 1'b0; div_result = JUNK;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({stall, busy, hilo_we} !== 3'b000) $display("FAIL reset_ctl: got %b expected 000", {stall, busy, hilo_we}); else passed++;
    checks++; if ({hi_out, lo_out} !== 64'd0) $display("FAIL reset_hilo: got %h expected 0", {hi_out, lo_out}); else passed++;
    checks++; if ({mult_a, mult_b} !== 64'd0) $display("FAIL reset_mult_ops: got %h expected 0", {mult_a, mult_b}); else passed++;
    checks++; if ({mult_sclr, div_start, div_signed, div_annul} !== 4'b0000)
      $display("FAIL reset_strobes: got %b expected 0000", {mult_sclr, div_start, div_signed, div_annul}); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int we, sn, stn, sgn; logic [31:0] ma, mb; logic [63:0] got, e;
    run_op(2'b01, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 0, JUNK, we, sn, stn, sgn, ma, mb, got);
    e = sb.pop_front(); last_exp = e;
    checks++; if (we !== MULT_LAT + 1) $display("FAIL multu_we_cycle: got %0d expected %0d", we, MULT_LAT + 1); else passed++;
    checks++; if (sn !== MULT_LAT + 1) $display("FAIL multu_stall_len: got %0d expected %0d", sn, MULT_LAT + 1); else passed++;
    checks++; if (got !== e) $display("FAIL multu_result: got %h expected %h", got, e); else passed++;
  endtask

  task automatic test_mult_signed();
    int we, sn, stn, sgn; logic [31:0] ma, mb; logic [63:0] got, e;
    run_op(2'b00, 32'hFFFF_FFFD, 32'h7, 64'hFFFF_FFFF_FFFF_FFEB, 0, JUNK, we, sn, stn, sgn, ma, mb, got);
    e = sb.pop_front(); last_exp = e;
    checks++; if ({ma, mb} !== {32'd3, 32'd7}) $display("FAIL mult_mag_ops: got %h expected %h", {ma, mb}, {32'd3, 32'd7}); else passed++;
    checks++; if (got !== e) $display("FAIL mult_neg_result: got %h expected %h", got, e); else passed++;
    run_op(2'b00, 32'h8000_0000, 32'h1, 64'hFFFF_FFFF_8000_0000, 0, JUNK, we, sn, stn, sgn, ma, mb, got);
    e = sb.pop_front(); last_exp = e;
    checks++; if (ma !== 32'h8000_0000) $display("FAIL mult_minint_op: got %h expected 80000000", ma); else passed++;
    checks++; if (got !== e) $display("FAIL mult_minint_result: got %h expected %h", got, e); else passed++;
    run_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'd6, 0, JUNK, we, sn, stn, sgn, ma, mb, got);
    e = sb.pop_front(); last_exp = e;
    checks++; if (got !== e) $display("FAIL mult_negneg_result: got %h expected %h", got, e); else passed++;
  endtask

  task automatic test_div();
    int we, sn, stn, sgn; logic [31:0] ma, mb; logic [63:0] got, e;
    run_op(2'b10, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 64'hFFFF_FFFF_FFFF_FFFD,
           we, sn, stn, sgn, ma, mb, got);
    e = sb.pop_front(); last_exp = e;
    checks++; if (stn !== 34) $display("FAIL div_start_len: got %0d expected 34", stn); else passed++;
    checks++; if (sgn !== 34) $display("FAIL div_signed_len: got %0d expected 34", sgn); else passed++;
    checks++; if (we !== 35) $display("FAIL div_we_cycle: got %0d expected 35", we); else passed++;
    checks++; if (got !== e) $display("FAIL div_result: got %h expected %h", got, e); else passed++;
  endtask

  task automatic test_flush();
    int we, sn, stn, sgn; logic [31:0] ma, mb; logic [63:0] got, e;
    logic we_seen = 1'b0;
    req_valid = 1'b1; req_op = 2'b00; src_a = 32'd5; src_b = 32'd6;
    for (int k = 0; k <= 10; k++) begin
      flush = (k == 3);
      @(negedge clk);
      if (k == 3) begin
        checks++; if ({mult_sclr, stall, div_annul} !== 3'b100)
          $display("FAIL flush_strobes: got %b expected 100", {mult_sclr, stall, div_annul}); else passed++;
      end
      if (k == 4) begin
        checks++; if (busy !== 1'b0) $display("FAIL flush_idle: got %b expected 0", busy); else passed++;
      end
      if (k >= 3 && hilo_we) we_seen = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    flush = 1'b0;
    checks++; if (we_seen !== 1'b0) $display("FAIL flush_no_we: got %b expected 0", we_seen); else passed++;
    run_op(2'b01, 32'd2, 32'd3, 64'd6, 0, JUNK, we, sn, stn, sgn, ma, mb, got);
    e = sb.pop_front(); last_exp = e;
    checks++; if (got !== e) $display("FAIL flush_next_result: got %h expected %h", got, e); else passed++;
  endtask

  task automatic test_stray_and_rst();
    int we, sn, stn, sgn; logic [31:0] ma, mb; logic [63:0] got, e;
    div_ready = 1'b1; div_result = JUNK;
    @(negedge clk);
    @(posedge clk); #1;
    div_ready = 1'b0;
    @(negedge clk);
    checks++; if ({busy, hilo_we} !== 2'b00) $display("FAIL stray_ready_ctl: got %b expected 00", {busy, hilo_we}); else passed++;
    checks++; if ({hi_out, lo_out} !== last_exp) $display("FAIL stray_ready_hilo: got %h expected %h", {hi_out, lo_out}, last_exp); else passed++;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b10; src_a = 32'd100; src_b = 32'd7;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({div_annul, stall, hilo_we} !== 3'b100)
      $display("FAIL rst_div_annul: got %b expected 100", {div_annul, stall, hilo_we}); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy, stall, hilo_we, div_start, div_signed, div_annul, mult_sclr} !== 7'd0)
      $display("FAIL rst_ctl: got %b expected 0000000", {busy, stall, hilo_we, div_start, div_signed, div_annul, mult_sclr}); else passed++;
    checks++; if ({hi_out, lo_out, mult_a, mult_b} !== 128'd0)
      $display("FAIL rst_regs: got %h expected 0", {hi_out, lo_out, mult_a, mult_b}); else passed++;
    @(posedge clk); #1;
    run_op(2'b11, 32'd10, 32'd3, 64'h0000_0001_0000_0003, 3, 64'h0000_0001_0000_0003,
           we, sn, stn, sgn, ma, mb, got);
    e = sb.pop_front(); last_exp = e;
    checks++; if (sgn !== 0) $display("FAIL divu_signed: got %0d expected 0", sgn); else passed++;
    checks++; if (got !== e) $display("FAIL divu_result: got %h expected %h", got, e); else passed++;
  endtask

  task automatic test_zero();
    int we, sn, stn, sgn, exp_we; logic [31:0] ma, mb; logic [63:0] got, e;
`ifdef MULDIV_ZERO_SKIP_EN
    exp_we = 1;
`else
    exp_we = MULT_LAT + 1;
`endif
    run_op(2'b00, 32'd0, 32'd5, 64'd0, 0, JUNK, we, sn, stn, sgn, ma, mb, got);
    e = sb.pop_front(); last_exp = e;
    checks++; if (we !== exp_we) $display("FAIL zero_we_cycle: got %0d expected %0d", we, exp_we); else passed++;
    checks++; if (sn !== exp_we) $display("FAIL zero_stall_len: got %0d expected %0d", sn, exp_we); else passed++;
    checks++; if (got !== e) $display("FAIL zero_result: got %h expected %h", got, e); else passed++;
  endtask

  task automatic test_back_to_back();
    int we, sn, stn, sgn; logic [31:0] ma, mb; logic [63:0] got, e;
    run_op(2'b01, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780, 0, JUNK, we, sn, stn, sgn, ma, mb, got);
    e = sb.pop_front();
    checks++; if (got !== e) $display("FAIL b2b_first: got %h expected %h", got, e); else passed++;
    run_op(2'b00, 32'h0000_0010, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 0, JUNK, we, sn, stn, sgn, ma, mb, got);
    e = sb.pop_front();
    checks++; if (we !== MULT_LAT + 1) $display("FAIL b2b_we_cycle: got %0d expected %0d", we, MULT_LAT + 1); else passed++;
    checks++; if (got !== e) $display("FAIL b2b_second: got %h expected %h", got, e); else passed++;
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
    test_div();
    test_flush();
    test_stray_and_rst();
    test_zero();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
